// File: rtl/ddr_burst_reader_pkg.sv
// ddr_burst_reader_pkg
//   Shared types and helpers for the DDR burst-read master.
//   state_t   : command FSM states (IDLE, ISSUE, WAIT)
//   FIFO_AW   : address width of the default-depth read-data FIFO
//   min_len() : smaller of two word counts
package ddr_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int unsigned DEF_FIFO_DEPTH = 64;
    localparam int unsigned FIFO_AW        = $clog2(DEF_FIFO_DEPTH);

    function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_burst_reader_if.sv
// ddr_burst_reader_if
//   Avalon-MM burst-read bus plus the ready/valid output stream.
//   master : the reader side (drives command, consumes read data, sources stream)
//   slave  : memory + stream consumer side
interface ddr_burst_reader_if #(
    parameter int unsigned ADDR_W  = 29,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned BURST_W = 8
) ();

    logic [ADDR_W-1:0]  ram_address;
    logic [BURST_W-1:0] ram_burstcount;
    logic               ram_read;
    logic               ram_waitrequest;
    logic [DATA_W-1:0]  ram_readdata;
    logic               ram_readdatavalid;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output ram_address, ram_burstcount, ram_read,
        input  ram_waitrequest, ram_readdata, ram_readdatavalid,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        input  ram_address, ram_burstcount, ram_read,
        output ram_waitrequest, ram_readdata, ram_readdatavalid,
        input  out_data, out_valid,
        output out_ready
    );

endinterface

// File: rtl/ddr_rd_fifo.sv
// ddr_rd_fifo
//   Synchronous first-word-fall-through FIFO, 2**AW entries.
//   clk, rst_n     : clock, synchronous active-low reset (empties the FIFO)
//   push/push_data : write one word
//   pop            : remove the head word (ignored when empty)
//   head/not_empty : current head word and its valid flag
//   count          : number of stored words (0..2**AW)
module ddr_rd_fifo
    import ddr_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned AW     = FIFO_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              not_empty,
    output logic [AW:0]       count
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign count     = count_q;

endmodule

// File: rtl/ddr_burst_reader.sv
// ddr_burst_reader
//   Avalon-MM burst-read master for one 64-bit DDR port. Reads cfg_len words
//   from cfg_addr upward and delivers them in order on a ready/valid stream.
//   A burst is only issued when the FIFO can hold every word still owed by
//   the slave, so readdatavalid never needs back-pressure.
//   ram_clk, reset_n : clock, synchronous active-low reset
//   start            : one-cycle pulse, latches cfg_addr/cfg_len when idle
//   cfg_addr/cfg_len : first word address / word count (0 is legal)
//   busy, done       : transfer in progress / one-cycle completion pulse
//   bus              : Avalon read master + output stream
module ddr_burst_reader
    import ddr_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 29,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BURST_W    = 8,
    parameter int unsigned MAX_BURST  = 32,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned LEN_W      = 24
) (
    input  logic              ram_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    ddr_burst_reader_if.master bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [CW-1:0]      pend_q, pend_d;
    logic [LEN_W-1:0]   deliver_q, deliver_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [BURST_W-1:0] ram_bc_q, ram_bc_d;

    logic [CW-1:0]      fifo_count;
    logic               fifo_valid;
    logic [DATA_W-1:0]  fifo_head;
    logic               push, pop, accept, last_pop;
    logic [BURST_W-1:0] blen;
    logic [CW-1:0]      credit;

    ddr_rd_fifo #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_fifo (
        .clk       (ram_clk),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (bus.ram_readdata),
        .pop       (pop),
        .head      (fifo_head),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

    always_comb begin
        // Words arriving while nothing is owed (e.g. stragglers from before a
        // reset) are discarded rather than stored.
        push     = bus.ram_readdatavalid && (pend_q != '0);
        pop      = fifo_valid && bus.out_ready;
        accept   = rd_q && !bus.ram_waitrequest;
        blen     = BURST_W'(min_len(MAX_BURST, 32'(remain_q)));
        credit   = CW'(FIFO_DEPTH) - fifo_count - pend_q;
        last_pop = pop && (deliver_q == LEN_W'(1));

        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_d       = rd_q;
        ram_addr_d = ram_addr_q;
        ram_bc_d   = ram_bc_q;
        // Accept and return may coincide; apply both as net arithmetic.
        pend_d     = pend_q + (accept ? CW'(ram_bc_q) : '0) - (push ? CW'(1) : '0);
        deliver_d  = deliver_q - (pop ? LEN_W'(1) : '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        addr_d    = cfg_addr;
                        remain_d  = cfg_len;
                        deliver_d = cfg_len;
                        busy_d    = 1'b1;
                        state_d   = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (32'(credit) >= 32'(blen)) begin
                    rd_d       = 1'b1;
                    ram_addr_d = addr_q;
                    ram_bc_d   = blen;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // With nothing left to request, WAIT doubles as the drain
                // phase until the final word leaves the stream.
                if (accept) begin
                    rd_d     = 1'b0;
                    addr_d   = addr_q + ADDR_W'(ram_bc_q);
                    remain_d = remain_q - LEN_W'(ram_bc_q);
                    if (remain_d != '0) begin
                        state_d = ISSUE;
                    end
                end
                if (last_pop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            pend_q     <= '0;
            deliver_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_bc_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            pend_q     <= pend_d;
            deliver_q  <= deliver_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            ram_addr_q <= ram_addr_d;
            ram_bc_q   <= ram_bc_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign bus.ram_read       = rd_q;
    assign bus.ram_address    = ram_addr_q;
    assign bus.ram_burstcount = ram_bc_q;
    assign bus.out_data       = fifo_head;
    assign bus.out_valid      = fifo_valid;

endmodule

// File: tb/tb_ddr_burst_reader.sv
// tb_ddr_burst_reader
//   Directed bench for ddr_burst_reader. dut_a uses the default configuration,
//   dut_b uses MAX_BURST=2 for the address-wrap case. A small Avalon slave
//   model returns pat(address) three cycles after each accepted command.
module tb_ddr_burst_reader;

    localparam int unsigned ADDR_W  = 29;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned LEN_W   = 24;

    logic ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    logic              reset_n;
    logic              start_a, start_b;
    logic [ADDR_W-1:0] cfg_addr_a, cfg_addr_b;
    logic [LEN_W-1:0]  cfg_len_a, cfg_len_b;
    logic              busy_a, done_a, busy_b, done_b;

    ddr_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus_a ();
    ddr_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus_b ();

    ddr_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .MAX_BURST(32), .FIFO_DEPTH(64), .LEN_W(LEN_W)
    ) dut_a (
        .ram_clk(ram_clk), .reset_n(reset_n), .start(start_a),
        .cfg_addr(cfg_addr_a), .cfg_len(cfg_len_a),
        .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    ddr_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .MAX_BURST(2), .FIFO_DEPTH(64), .LEN_W(LEN_W)
    ) dut_b (
        .ram_clk(ram_clk), .reset_n(reset_n), .start(start_b),
        .cfg_addr(cfg_addr_b), .cfg_len(cfg_len_b),
        .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic logic [63:0] pat(input logic [28:0] a);
        return {3'b101, a, 3'b010, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge ram_clk);
        #1;
    endtask

    // ---------------- slave model / stream monitor ----------------
    int unsigned cyc = 0;
    always @(posedge ram_clk) cyc++;

    int unsigned ra_addr[$], ra_cnt[$], ra_due[$];
    int unsigned rb_addr[$], rb_cnt[$], rb_due[$];
    int unsigned ra_idx = 0, rb_idx = 0;
    int unsigned acc_a_addr[$], acc_a_cnt[$], acc_b_addr[$], acc_b_cnt[$];
    int unsigned issued_a = 0, pops_a = 0, max_out_a = 0, rv_a = 0, pops_b = 0;
    logic [28:0] exp_a = '0, exp_b = '0;

    // Commands and pops are sampled mid-cycle; they take effect on the next edge.
    always @(negedge ram_clk) begin
        if (reset_n && bus_a.ram_read && !bus_a.ram_waitrequest) begin
            acc_a_addr.push_back(32'(bus_a.ram_address));
            acc_a_cnt.push_back(32'(bus_a.ram_burstcount));
            ra_addr.push_back(32'(bus_a.ram_address));
            ra_cnt.push_back(32'(bus_a.ram_burstcount));
            ra_due.push_back(cyc + 3);
            issued_a += 32'(bus_a.ram_burstcount);
        end
        if (reset_n && bus_a.out_valid && bus_a.out_ready) begin
            chk("a_stream", bus_a.out_data, pat(exp_a));
            exp_a = exp_a + 1'b1;
            pops_a++;
        end
        if (bus_a.ram_readdatavalid) rv_a++;
        if (issued_a - pops_a > max_out_a) max_out_a = issued_a - pops_a;
    end

    always @(negedge ram_clk) begin
        if (reset_n && bus_b.ram_read && !bus_b.ram_waitrequest) begin
            acc_b_addr.push_back(32'(bus_b.ram_address));
            acc_b_cnt.push_back(32'(bus_b.ram_burstcount));
            rb_addr.push_back(32'(bus_b.ram_address));
            rb_cnt.push_back(32'(bus_b.ram_burstcount));
            rb_due.push_back(cyc + 3);
        end
        if (reset_n && bus_b.out_valid && bus_b.out_ready) begin
            chk("b_stream", bus_b.out_data, pat(exp_b));
            exp_b = exp_b + 1'b1;
            pops_b++;
        end
    end

    always @(posedge ram_clk) begin
        #1;
        if (ra_addr.size() != 0 && cyc >= ra_due[0]) begin
            bus_a.ram_readdatavalid = 1'b1;
            bus_a.ram_readdata      = pat(29'(ra_addr[0] + ra_idx));
            ra_idx++;
            if (ra_idx == ra_cnt[0]) begin
                void'(ra_addr.pop_front()); void'(ra_cnt.pop_front()); void'(ra_due.pop_front());
                ra_idx = 0;
            end
        end else begin
            bus_a.ram_readdatavalid = 1'b0;
        end
    end

    always @(posedge ram_clk) begin
        #1;
        if (rb_addr.size() != 0 && cyc >= rb_due[0]) begin
            bus_b.ram_readdatavalid = 1'b1;
            bus_b.ram_readdata      = pat(29'(rb_addr[0] + rb_idx));
            rb_idx++;
            if (rb_idx == rb_cnt[0]) begin
                void'(rb_addr.pop_front()); void'(rb_cnt.pop_front()); void'(rb_due.pop_front());
                rb_idx = 0;
            end
        end else begin
            bus_b.ram_readdatavalid = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int unsigned p0;
        bit stray;
        reset_n = 1'b0;
        start_a = 1'b0; cfg_addr_a = '0; cfg_len_a = '0;
        start_b = 1'b0; cfg_addr_b = '0; cfg_len_b = '0;
        bus_a.ram_waitrequest = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.ram_waitrequest = 1'b0; bus_b.out_ready = 1'b1;
        tick(3);

        // Reset state
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_read", 64'(bus_a.ram_read), 64'd0);
        chk("rst_addr", 64'(bus_a.ram_address), 64'd0);
        chk("rst_bc", 64'(bus_a.ram_burstcount), 64'd0);
        chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
        reset_n = 1'b1;
        tick(1);

        // Length 0
        cfg_addr_a = 29'h100; cfg_len_a = '0; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("len0_done", 64'(done_a), 64'd1);
        chk("len0_busy", 64'(busy_a), 64'd0);
        chk("len0_read", 64'(bus_a.ram_read), 64'd0);
        tick(1);
        chk("len0_done_off", 64'(done_a), 64'd0);
        tick(3);
        chk("len0_no_cmd", 64'(acc_a_addr.size()), 64'd0);

        // Basic 5-word burst
        exp_a = 29'h100; p0 = pops_a;
        cfg_addr_a = 29'h100; cfg_len_a = 24'd5; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("b5_busy", 64'(busy_a), 64'd1);
        chk("b5_read_early", 64'(bus_a.ram_read), 64'd0);
        tick(1);
        chk("b5_read", 64'(bus_a.ram_read), 64'd1);
        chk("b5_addr", 64'(bus_a.ram_address), 64'h100);
        chk("b5_bc", 64'(bus_a.ram_burstcount), 64'd5);
        for (int i = 0; i < 100 && !done_a; i++) tick(1);
        chk("b5_done", 64'(done_a), 64'd1);
        chk("b5_busy_off", 64'(busy_a), 64'd0);
        chk("b5_pops", 64'(pops_a - p0), 64'd5);
        chk("b5_ncmd", 64'(acc_a_addr.size()), 64'd1);
        tick(1);
        chk("b5_done_pulse", 64'(done_a), 64'd0);

        // Split bursts with waitrequest stall on the second command
        acc_a_addr.delete(); acc_a_cnt.delete();
        exp_a = 29'h100; p0 = pops_a;
        cfg_addr_a = 29'h100; cfg_len_a = 24'd70; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        for (int i = 0; i < 20 && acc_a_addr.size() == 0; i++) tick(1);
        bus_a.ram_waitrequest = 1'b1;
        for (int i = 0; i < 20 && !bus_a.ram_read; i++) tick(1);
        for (int i = 0; i < 4; i++) begin
            chk("sp_hold_read", 64'(bus_a.ram_read), 64'd1);
            chk("sp_hold_addr", 64'(bus_a.ram_address), 64'h120);
            chk("sp_hold_bc", 64'(bus_a.ram_burstcount), 64'd32);
            tick(1);
        end
        bus_a.ram_waitrequest = 1'b0;
        for (int i = 0; i < 300 && !done_a; i++) tick(1);
        chk("sp_done", 64'(done_a), 64'd1);
        chk("sp_pops", 64'(pops_a - p0), 64'd70);
        chk("sp_ncmd", 64'(acc_a_addr.size()), 64'd3);
        if (acc_a_addr.size() == 3) begin
            chk("sp_a0", 64'(acc_a_addr[0]), 64'h100); chk("sp_c0", 64'(acc_a_cnt[0]), 64'd32);
            chk("sp_a1", 64'(acc_a_addr[1]), 64'h120); chk("sp_c1", 64'(acc_a_cnt[1]), 64'd32);
            chk("sp_a2", 64'(acc_a_addr[2]), 64'h140); chk("sp_c2", 64'(acc_a_cnt[2]), 64'd6);
        end
        tick(2);

        // Back-pressure: 200 words, consumer stalled
        acc_a_addr.delete(); acc_a_cnt.delete();
        bus_a.out_ready = 1'b0;
        exp_a = 29'h1000; p0 = pops_a; max_out_a = 0;
        cfg_addr_a = 29'h1000; cfg_len_a = 24'd200; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(100);
        chk("bp_outstanding", 64'(issued_a - pops_a), 64'd64);
        chk("bp_ncmd", 64'(acc_a_addr.size()), 64'd2);
        chk("bp_read_off", 64'(bus_a.ram_read), 64'd0);
        chk("bp_head", bus_a.out_data, pat(29'h1000));
        tick(5);
        chk("bp_head_stable", bus_a.out_data, pat(29'h1000));
        bus_a.out_ready = 1'b1;
        tick(31);
        bus_a.out_ready = 1'b0;
        tick(10);
        chk("bp_31_pops", 64'(pops_a - p0), 64'd31);
        chk("bp_no_issue", 64'(acc_a_addr.size()), 64'd2);
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 2000 && !done_a; i++) tick(1);
        chk("bp_done", 64'(done_a), 64'd1);
        chk("bp_pops", 64'(pops_a - p0), 64'd200);
        chk("bp_ncmd_all", 64'(acc_a_addr.size()), 64'd7);
        chk("bp_max_out", 64'(max_out_a <= 64), 64'd1);
        if (acc_a_addr.size() == 7) begin
            chk("bp_last_addr", 64'(acc_a_addr[6]), 64'h10C0);
            chk("bp_last_bc", 64'(acc_a_cnt[6]), 64'd8);
        end
        tick(2);

        // Address wrap on the MAX_BURST=2 instance
        exp_b = 29'h1FFF_FFFE;
        cfg_addr_b = 29'h1FFF_FFFE; cfg_len_b = 24'd4; start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int i = 0; i < 100 && !done_b; i++) tick(1);
        chk("wr_done", 64'(done_b), 64'd1);
        chk("wr_pops", 64'(pops_b), 64'd4);
        chk("wr_ncmd", 64'(acc_b_addr.size()), 64'd2);
        if (acc_b_addr.size() == 2) begin
            chk("wr_a0", 64'(acc_b_addr[0]), 64'h1FFF_FFFE); chk("wr_c0", 64'(acc_b_cnt[0]), 64'd2);
            chk("wr_a1", 64'(acc_b_addr[1]), 64'h0);        chk("wr_c1", 64'(acc_b_cnt[1]), 64'd2);
        end
        tick(2);

        // Reset in the middle of a transfer with 10 words buffered
        bus_a.out_ready = 1'b0;
        exp_a = 29'h100; p0 = rv_a;
        cfg_addr_a = 29'h100; cfg_len_a = 24'd70; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        for (int i = 0; i < 100 && (rv_a - p0) < 10; i++) tick(1);
        chk("mr_buffered", 64'(rv_a - p0), 64'd10);
        reset_n = 1'b0;
        tick(1);
        chk("mr_busy", 64'(busy_a), 64'd0);
        chk("mr_done", 64'(done_a), 64'd0);
        chk("mr_read", 64'(bus_a.ram_read), 64'd0);
        chk("mr_addr", 64'(bus_a.ram_address), 64'd0);
        chk("mr_bc", 64'(bus_a.ram_burstcount), 64'd0);
        chk("mr_valid", 64'(bus_a.out_valid), 64'd0);
        reset_n = 1'b1;
        bus_a.out_ready = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 300 && ra_addr.size() != 0; i++) begin
            if (bus_a.out_valid) stray = 1'b1;
            tick(1);
        end
        tick(3);
        if (bus_a.out_valid) stray = 1'b1;
        chk("mr_drained", 64'(ra_addr.size()), 64'd0);
        chk("mr_stray_dropped", 64'(stray), 64'd0);
        exp_a = 29'h200; p0 = pops_a;
        cfg_addr_a = 29'h200; cfg_len_a = 24'd3; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        for (int i = 0; i < 100 && !done_a; i++) tick(1);
        chk("mr_new_done", 64'(done_a), 64'd1);
        tick(5);
        chk("mr_new_pops", 64'(pops_a - p0), 64'd3);
        chk("mr_new_empty", 64'(bus_a.out_valid), 64'd0);
        chk("mr_new_idle", 64'(busy_a), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_burst_reader.md
Name: ddr_burst_reader

Overview:
- Avalon-MM burst-read master for one 64-bit DDR3 port of the HPS memory bridge (ram1/ram2 channel), clocked by that port's clock.
- Fetches a programmed span of 64-bit words starting at a word address and delivers them in order on a ready/valid stream to core logic (audio/ROM streaming).
- Issues a burst only when the internal FIFO can absorb every outstanding word, so readdatavalid is never back-pressured.

Parameters:
- ADDR_W, 29, Avalon word-address width (64-bit words).
- DATA_W, 64, data width.
- BURST_W, 8, burstcount width.
- MAX_BURST, 32, largest burst issued; 1..2**(BURST_W-1).
- FIFO_DEPTH, 64, read-data FIFO entries; power of two, >= MAX_BURST.
- LEN_W, 24, transfer length width in words.

Ports:
- ram_clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches cfg_addr/cfg_len; ignored while busy=1.
- cfg_addr  in  ADDR_W  first word address.
- cfg_len  in  LEN_W  word count; 0 is legal.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the last word leaves the stream.
- ram_address  out  ADDR_W  burst start address.
- ram_burstcount  out  BURST_W  burst length.
- ram_read  out  1  read command.
- ram_waitrequest  in  1  slave stall.
- ram_readdata  in  DATA_W  returned data.
- ram_readdatavalid  in  1  returned-data strobe.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (reset_n=0 at an edge):
  - busy=0, done=0, ram_read=0, ram_address=0, ram_burstcount=0, out_valid=0.
  - FIFO emptied; counters cleared.
  - Applies mid-transfer as well: in-flight readdatavalid words arriving after reset are dropped.
- Registers:
  - addr_q: next burst address.
  - remain_q: words not yet requested.
  - pend_q: words requested but not yet returned (max FIFO_DEPTH).
  - deliver_q: words not yet popped to the stream.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - start=1 with cfg_len>0: latch addr_q=cfg_addr, remain_q=deliver_q=cfg_len; busy=1 next cycle; go ISSUE.
  - start=1 with cfg_len=0: done=1 on the next cycle, busy stays 0, no command issued.
- ISSUE:
  - Let blen = min(MAX_BURST, remain_q) and credit = FIFO_DEPTH - fifo_count - pend_q.
  - If credit >= blen: assert ram_read with ram_address=addr_q and ram_burstcount=blen, go WAIT.
  - Otherwise hold ram_read=0.
  - Earliest command: first ram_read is in the cycle after the start edge plus one (start at edge N, ram_read=1 from edge N+2).
- WAIT:
  - ram_read, ram_address and ram_burstcount stay stable while ram_waitrequest=1.
  - Command accepted on the edge where ram_read=1 and ram_waitrequest=0. At that edge: addr_q+=blen (wraps modulo 2**ADDR_W), remain_q-=blen, pend_q+=blen, ram_read=0.
  - Next state: ISSUE if remain_q>0, else IDLE-pending.
- Read data:
  - Every ram_readdatavalid pushes ram_readdata into the FIFO and decrements pend_q.
  - Overflow is impossible by the credit rule; a bench assertion checks this.
  - Accept and pop in the same cycle update pend_q/fifo_count consistently (net arithmetic, no lost counts).
- Stream:
  - FIFO is first-word-fall-through; out_valid = FIFO not empty; out_data = head.
  - Pop when out_valid && out_ready; deliver_q decrements on each pop.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Completion:
  - The pop that brings deliver_q to 0 returns FSM to IDLE with busy=0 and done=1 on the following cycle, for exactly one cycle.
  - A start in that same cycle is accepted (busy was 0).
- Data order equals address order; the slave returns bursts in order.

Decomposition:
- Package ddr_burst_reader_pkg:
  - state_t enum {IDLE, ISSUE, WAIT}.
  - Function min_len().
  - Localparam FIFO_AW = $clog2(FIFO_DEPTH).
- Sub-module ddr_rd_fifo: synchronous FWFT FIFO with count output and synchronous active-low reset.

Test Plan:
- Length 0: cfg_addr=0x100, cfg_len=0, start -> done pulse one cycle later; ram_read never asserted; busy stays 0.
- Basic burst: cfg_len=5, waitrequest=0, out_ready=1, data returns 3 cycles after accept -> single command address 0x100, burstcount 5; stream words in address order; done after the 5th pop.
- Split bursts: cfg_len=70, MAX_BURST=32 -> bursts 32@0x100, 32@0x120, 6@0x140; waitrequest held high 4 cycles on the second burst -> address/burstcount stable throughout.
- Back-pressure: cfg_len=200, out_ready=0 -> at most FIFO_DEPTH=64 words ever requested-but-unpopped; no further ram_read until pops free 32 credits; release out_ready -> all 200 words, no overflow.
- Wrap: cfg_addr=2**29-2, cfg_len=4 -> two bursts (MAX_BURST=2 configuration) at 0x1FFFFFFE and 0x0.
- Mid reset: reset_n=0 during the second burst with 10 words in the FIFO -> next cycle all outputs at reset values; a following start with cfg_len=3 completes cleanly with exactly 3 words.
